lfsr_keystream_sched: RTL

Round-robin scheduler that shares one 4-bit Fibonacci LFSR (feedback `{s[2:0], s[3]^s[2]}`, period 15) among several keystream consumers. Each granted requester receives one `WORD_W`-bit keystream word assembled serially from the LFSR output bit. The block also owns seed loading and lock-up protection. It sits between the LFSR datapath and the cipher/mixing stages that consume keystream.

---
 rtl/lfsr_keystream_sched_pkg.sv | 20 ++
 rtl/lfsr_keystream_sched_lfsr4_core.sv | 30 +++
 rtl/lfsr_keystream_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lfsr_keystream_sched_pkg.sv
// rtl/lfsr_keystream_sched_pkg.sv - shared types and LFSR helpers for the keystream scheduler
// Contents: scheduler state enum, LFSR width/reset value, one-step feedback function.
package lfsr_sched_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_RST = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Fibonacci step, period 15 over the non-zero states.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/lfsr_keystream_sched_lfsr4_core.sv
// rtl/lfsr_keystream_sched_lfsr4_core.sv - 4-bit LFSR register with seed load and lock-up guard
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (state -> LFSR_RST)
//   i_load         load i_seed this cycle (takes priority over i_step)
//   i_seed         seed value; all-zero is replaced by LFSR_RST
//   i_step         advance one step
//   o_state        current LFSR state (registered)
module lfsr4_core
  import lfsr_sched_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_state <= LFSR_RST;
    end else if (i_load) begin
      // All-zero is a fixed point of the feedback, so it must never be loaded.
      o_state <= (i_seed == '0) ? LFSR_RST : i_seed;
    end else if (i_step) begin
      o_state <= lfsr_next(o_state);
    end
  end

endmodule

// File: rtl/lfsr_keystream_sched.sv
// rtl/lfsr_keystream_sched.sv - round-robin scheduler sharing one LFSR among keystream consumers
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_seed_load    seed load strobe, honoured in IDLE only
//   i_seed         seed value captured with i_seed_load
//   i_req          level request per consumer, sampled in IDLE only
//   o_gnt          one-hot grant, held from grant through DONE
//   o_data         keystream word (LSB = first LFSR bit), valid with o_valid
//   o_valid        one-cycle pulse in DONE
//   o_busy         high whenever the FSM is not in IDLE
//   o_lfsr         current LFSR state
module lfsr_keystream_sched
  import lfsr_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic [LFSR_W-1:0] o_lfsr
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win_q;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] seed_q;
  logic [LFSR_W-1:0] lfsr;

  // Round-robin pick: first set request at or above ptr, wrapping modulo N_REQ.
  // The extra bit on idx_sum holds ptr+i before the wrap subtraction.
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  logic [PTR_W:0]   idx_sum;

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    idx_sum    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_sum = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (idx_sum >= (PTR_W + 1)'(N_REQ)) begin
        idx_sum = idx_sum - (PTR_W + 1)'(N_REQ);
      end
      if (!pick_found && i_req[idx_sum[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = idx_sum[PTR_W-1:0];
      end
    end
  end

  // The seed is applied during LOAD from the copy captured in IDLE, so a
  // strobe that drops after IDLE still loads the intended value.
  lfsr4_core u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (state == ST_LOAD),
    .i_seed  (seed_q),
    .i_step  (state == ST_SHIFT),
    .o_state (lfsr)
  );

  assign o_lfsr = lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win_q   <= '0;
      cnt     <= '0;
      seed_q  <= '0;
      o_gnt   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_seed_load) begin
            seed_q <= i_seed;
            state  <= ST_LOAD;
            o_busy <= 1'b1;
          end else if (pick_found) begin
            win_q  <= pick_idx;
            o_gnt  <= N_REQ'(1) << pick_idx;
            cnt    <= '0;
            o_data <= '0;
            state  <= ST_SHIFT;
            o_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        ST_SHIFT: begin
          // lfsr is the pre-step value here; the core steps on this same edge.
          o_data <= o_data | (WORD_W'(lfsr[0]) << cnt);
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state   <= ST_DONE;
            o_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          ptr     <= (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
          o_gnt   <= '0;
          o_valid <= 1'b0;
          state   <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
